// File: rtl/counter_sweep_ctrl.sv
// Sweep controller for an external up/down counter: loads lo, counts lo->hi->lo
// for a requested number of passes, with hold, abort and start validation.
module counter_sweep_ctrl #(
  parameter int N        = 8,
  parameter int PASSES_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                hold_i,
  input  logic [N-1:0]        lo_i,
  input  logic [N-1:0]        hi_i,
  input  logic [PASSES_W-1:0] passes_i,
  input  logic [N-1:0]        count_i,
  output logic                ctr_load_o,
  output logic [N-1:0]        ctr_load_val_o,
  output logic                ctr_en_o,
  output logic                ctr_up_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                err_o,
  output logic [PASSES_W-1:0] pass_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_UP,
    S_DOWN,
    S_DONE
  } state_t;

  state_t              state_reg, state_next;
  logic [N-1:0]        lo_reg, lo_next;
  logic [N-1:0]        hi_reg, hi_next;
  logic [PASSES_W-1:0] passes_reg, passes_next;
  logic [PASSES_W-1:0] pass_cnt_reg, pass_cnt_next;
  logic                err_reg, err_next;
  logic [PASSES_W-1:0] pass_cnt_inc;
  logic                last_pass;

  // pass_cnt stays below passes_reg while running, so the increment cannot wrap
  assign pass_cnt_inc = pass_cnt_reg + {{(PASSES_W-1){1'b0}}, 1'b1};
  assign last_pass    = (pass_cnt_inc == passes_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      lo_reg       <= '0;
      hi_reg       <= '0;
      passes_reg   <= '0;
      pass_cnt_reg <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      lo_reg       <= lo_next;
      hi_reg       <= hi_next;
      passes_reg   <= passes_next;
      pass_cnt_reg <= pass_cnt_next;
      err_reg      <= err_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    lo_next       = lo_reg;
    hi_next       = hi_reg;
    passes_next   = passes_reg;
    pass_cnt_next = pass_cnt_reg;
    err_next      = 1'b0;
    ctr_load_o    = 1'b0;
    ctr_en_o      = 1'b0;
    ctr_up_o      = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (start_i) begin
          if ((lo_i < hi_i) && (passes_i != '0)) begin
            lo_next       = lo_i;
            hi_next       = hi_i;
            passes_next   = passes_i;
            pass_cnt_next = '0;
            state_next    = S_LOAD;
          end else begin
            err_next = 1'b1;
          end
        end
      end

      S_LOAD: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_next = S_IDLE;
        end else begin
          ctr_load_o = 1'b1;
          state_next = S_UP;
        end
      end

      S_UP: begin
        busy_o   = 1'b1;
        ctr_up_o = (count_i != hi_reg);
        if (abort_i) begin
          state_next = S_IDLE;
        end else if (!hold_i) begin
          ctr_en_o = 1'b1;
          if (count_i == hi_reg) begin
            state_next = S_DOWN;
          end
        end
      end

      S_DOWN: begin
        busy_o = 1'b1;
        if (abort_i) begin
          state_next = S_IDLE;
        end else if (!hold_i) begin
          if (count_i != lo_reg) begin
            ctr_en_o = 1'b1;
          end else if (last_pass) begin
            pass_cnt_next = pass_cnt_inc;
            state_next    = S_DONE;
          end else begin
            // turn around at lo without a dead cycle
            pass_cnt_next = pass_cnt_inc;
            ctr_en_o      = 1'b1;
            ctr_up_o      = 1'b1;
            state_next    = S_UP;
          end
        end
      end

      S_DONE: begin
        done_o     = 1'b1;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign ctr_load_val_o = lo_reg;
  assign err_o          = err_reg;
  assign pass_cnt_o     = pass_cnt_reg;

endmodule

// File: doc/counter_sweep_ctrl.md
COUNTER_SWEEP_CTRL -- requirements
Module: counter_sweep_ctrl

Interface
REQ-001 Parameter N, default 8, width of counter value ports.
REQ-002 Parameter PASSES_W, default 4, width of the pass-count ports.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on its rising edge.
REQ-005 rst  input  1  synchronous reset, active high.
REQ-006 start_i  input  1  request a sweep run; sampled only in IDLE.
REQ-007 abort_i  input  1  terminate a run in progress.
REQ-008 hold_i  input  1  pause counting; state and pass count frozen.
REQ-009 lo_i  input  N  sweep lower bound, unsigned.
REQ-010 hi_i  input  N  sweep upper bound, unsigned.
REQ-011 passes_i  input  PASSES_W  number of full lo->hi->lo passes.
REQ-012 count_i  input  N  registered value of the controlled up/down counter.
REQ-013 ctr_load_o  output  1  counter load strobe.
REQ-014 ctr_load_val_o  output  N  counter load value.
REQ-015 ctr_en_o  output  1  counter enable.
REQ-016 ctr_up_o  output  1  counter direction: 1 up, 0 down.
REQ-017 busy_o  output  1  high in LOAD, UP and DOWN.
REQ-018 done_o  output  1  one-cycle pulse on normal completion.
REQ-019 err_o  output  1  one-cycle pulse on rejected start.
REQ-020 pass_cnt_o  output  PASSES_W  completed passes of the current or last run.

Function
REQ-021 The FSM SHALL have states IDLE, LOAD, UP, DOWN and DONE.
REQ-022 IDLE: start_i=1 with lo_i<hi_i and passes_i!=0 SHALL latch lo_q, hi_q and passes_q, clear pass_cnt, and go to LOAD.
REQ-023 IDLE: start_i=1 with lo_i>=hi_i or passes_i==0 SHALL pulse err_o for one cycle and stay in IDLE, with latched values and pass_cnt unchanged.
REQ-024 LOAD: ctr_load_o=1 and ctr_load_val_o=lo_q for exactly one cycle, then go to UP; ctr_load_val_o=lo_q in all other states.
REQ-025 UP: ctr_en_o=~hold_i and ctr_up_o=(count_i!=hi_q); when count_i==hi_q and hold_i=0, go to DOWN.
REQ-026 DOWN, count_i!=lo_q: ctr_en_o=~hold_i, ctr_up_o=0.
REQ-027 DOWN, count_i==lo_q, hold_i=0, pass_cnt+1<passes_q: pass_cnt increments, ctr_en_o=1, ctr_up_o=1, next state UP.
REQ-028 DOWN, count_i==lo_q, hold_i=0, pass_cnt+1==passes_q: pass_cnt increments, ctr_en_o=0, next state DONE.
REQ-029 DONE: done_o=1 for one cycle, then IDLE.
REQ-030 ctr_en_o, ctr_load_o and ctr_up_o SHALL be 0 in IDLE and DONE.
REQ-031 hold_i=1 SHALL force ctr_en_o=0 and block state and pass_cnt changes in UP and DOWN; hold_i has no effect in LOAD.
REQ-032 abort_i=1 in LOAD, UP or DOWN SHALL force ctr_en_o=0 and ctr_load_o=0 that cycle and go to IDLE next; done_o not asserted; pass_cnt retained.
REQ-033 abort_i SHALL take priority over hold_i and over pass completion.
REQ-034 start_i while busy_o=1 or in DONE SHALL be ignored.
REQ-035 Latency: start accepted at edge k, LOAD in cycle k+1, count_i=lo_q from cycle k+2.
REQ-036 Each pass SHALL be 2*(hi_q-lo_q) counter steps; pass_cnt SHALL never exceed passes_q.
REQ-037 pass_cnt_o SHALL hold its value in IDLE until the next accepted start.

Reset
REQ-038 rst=1 at a clock edge SHALL force IDLE, pass_cnt=0, lo_q=hi_q=passes_q=0, and all outputs 0, overriding all other inputs, including mid-run.

Verification
REQ-039 lo=3, hi=5, passes=2, start at T0 -> LOAD T1; count_i 3,4,5,4,3,4,5,4,3 over T2..T10; ctr_en_o=0 at T10; done_o=1 at T11; pass_cnt_o=2; IDLE at T12.
REQ-040 Same run with hold_i=1 for 3 cycles while count_i=4 in UP -> ctr_en_o=0 and state frozen for 3 cycles; done_o delayed by exactly 3 cycles.
REQ-041 abort_i=1 while count_i=5 in pass 1 of the REQ-039 run -> ctr_en_o=0 that cycle; IDLE next; done_o never asserted; pass_cnt_o=0.
REQ-042 start with lo=7, hi=7 and again with lo=2, hi=9, passes=0 -> err_o pulses once each; busy_o stays 0; ctr_* outputs stay 0.
REQ-043 rst=1 in DOWN mid-run -> next cycle IDLE, all outputs 0, pass_cnt_o=0; a new start is accepted normally afterwards.
REQ-044 start_i held high for the whole REQ-039 run -> exactly one run; a second run begins only on a start sampled in IDLE after done_o.
